// File: rtl/cpu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_ctrl_pkg
// Brief    : Opcodes, ALU operation codes, sequencer states, instruction
//            classes and the opcode-to-ALU_op mapping shared by the control unit.
// Revision : 1.0
// ============================================================================
package cpu_ctrl_pkg;

    localparam logic [4:0] C_OP_LD   = 5'b00000;
    localparam logic [4:0] C_OP_LDI  = 5'b00001;
    localparam logic [4:0] C_OP_ST   = 5'b00010;
    localparam logic [4:0] C_OP_ADD  = 5'b00011;
    localparam logic [4:0] C_OP_SUB  = 5'b00100;
    localparam logic [4:0] C_OP_AND  = 5'b00101;
    localparam logic [4:0] C_OP_OR   = 5'b00110;
    localparam logic [4:0] C_OP_ROR  = 5'b00111;
    localparam logic [4:0] C_OP_ROL  = 5'b01000;
    localparam logic [4:0] C_OP_SHR  = 5'b01001;
    localparam logic [4:0] C_OP_SHRA = 5'b01010;
    localparam logic [4:0] C_OP_SHL  = 5'b01011;
    localparam logic [4:0] C_OP_ADDI = 5'b01100;
    localparam logic [4:0] C_OP_ANDI = 5'b01101;
    localparam logic [4:0] C_OP_ORI  = 5'b01110;
    localparam logic [4:0] C_OP_MUL  = 5'b01111;
    localparam logic [4:0] C_OP_DIV  = 5'b10000;
    localparam logic [4:0] C_OP_NEG  = 5'b10001;
    localparam logic [4:0] C_OP_BR   = 5'b10010;
    localparam logic [4:0] C_OP_NOT  = 5'b10011;
    localparam logic [4:0] C_OP_MFHI = 5'b10111;
    localparam logic [4:0] C_OP_MFLO = 5'b11000;
    localparam logic [4:0] C_OP_NOP  = 5'b11010;
    localparam logic [4:0] C_OP_HALT = 5'b11011;

    // Zero is reserved for "no ALU operation" so idle steps drive ALU_op low.
    localparam logic [4:0] C_ALU_NONE = 5'd0;
    localparam logic [4:0] C_ALU_ADD  = 5'd1;
    localparam logic [4:0] C_ALU_SUB  = 5'd2;
    localparam logic [4:0] C_ALU_AND  = 5'd3;
    localparam logic [4:0] C_ALU_OR   = 5'd4;
    localparam logic [4:0] C_ALU_SHR  = 5'd5;
    localparam logic [4:0] C_ALU_SHRA = 5'd6;
    localparam logic [4:0] C_ALU_SHL  = 5'd7;
    localparam logic [4:0] C_ALU_ROR  = 5'd8;
    localparam logic [4:0] C_ALU_ROL  = 5'd9;
    localparam logic [4:0] C_ALU_MUL  = 5'd10;
    localparam logic [4:0] C_ALU_DIV  = 5'd11;
    localparam logic [4:0] C_ALU_NEG  = 5'd12;
    localparam logic [4:0] C_ALU_NOT  = 5'd13;

    // Bit 3 marks an executing step; bits [2:0] are then the step index.
    typedef enum logic [3:0] {
        ST_RST  = 4'b0000,
        ST_HALT = 4'b0001,
        ST_T0   = 4'b1000,
        ST_T1   = 4'b1001,
        ST_T2   = 4'b1010,
        ST_T3   = 4'b1011,
        ST_T4   = 4'b1100,
        ST_T5   = 4'b1101,
        ST_T6   = 4'b1110,
        ST_T7   = 4'b1111
    } state_t;

    typedef enum logic [3:0] {
        CLS_RALU   = 4'd0,
        CLS_IALU   = 4'd1,
        CLS_MULDIV = 4'd2,
        CLS_LD     = 4'd3,
        CLS_ST     = 4'd4,
        CLS_LDI    = 4'd5,
        CLS_BR     = 4'd6,
        CLS_MFHI   = 4'd7,
        CLS_MFLO   = 4'd8,
        CLS_NOP    = 4'd9,
        CLS_HALT   = 4'd10
    } instr_class_t;

    function automatic logic [4:0] alu_op_of(input logic [4:0] opcode);
        case (opcode)
            C_OP_LD, C_OP_LDI, C_OP_ST,
            C_OP_ADD, C_OP_ADDI:        alu_op_of = C_ALU_ADD;
            C_OP_SUB:                   alu_op_of = C_ALU_SUB;
            C_OP_AND, C_OP_ANDI:        alu_op_of = C_ALU_AND;
            C_OP_OR, C_OP_ORI:          alu_op_of = C_ALU_OR;
            C_OP_ROR:                   alu_op_of = C_ALU_ROR;
            C_OP_ROL:                   alu_op_of = C_ALU_ROL;
            C_OP_SHR:                   alu_op_of = C_ALU_SHR;
            C_OP_SHRA:                  alu_op_of = C_ALU_SHRA;
            C_OP_SHL:                   alu_op_of = C_ALU_SHL;
            C_OP_MUL:                   alu_op_of = C_ALU_MUL;
            C_OP_DIV:                   alu_op_of = C_ALU_DIV;
            C_OP_NEG:                   alu_op_of = C_ALU_NEG;
            C_OP_NOT:                   alu_op_of = C_ALU_NOT;
            default:                    alu_op_of = C_ALU_NONE;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/ctrl_decode.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_decode
// Brief    : Maps the instruction opcode to an execution class and ALU code.
// Revision : 1.0
// ============================================================================
module ctrl_decode
    import cpu_ctrl_pkg::*;
(
    input  logic [4:0]   opcode,
    output instr_class_t instr_class,
    output logic [4:0]   alu_op
);

    always_comb begin
        instr_class = CLS_NOP;
        case (opcode)
            C_OP_ADD, C_OP_SUB, C_OP_AND, C_OP_OR, C_OP_ROR,
            C_OP_ROL, C_OP_SHR, C_OP_SHRA, C_OP_SHL:    instr_class = CLS_RALU;
            C_OP_ADDI, C_OP_ANDI, C_OP_ORI:             instr_class = CLS_IALU;
            C_OP_MUL, C_OP_DIV:                         instr_class = CLS_MULDIV;
            C_OP_LD:                                    instr_class = CLS_LD;
            C_OP_ST:                                    instr_class = CLS_ST;
            C_OP_LDI:                                   instr_class = CLS_LDI;
            C_OP_BR:                                    instr_class = CLS_BR;
            C_OP_MFHI:                                  instr_class = CLS_MFHI;
            C_OP_MFLO:                                  instr_class = CLS_MFLO;
            C_OP_HALT:                                  instr_class = CLS_HALT;
            default:                                    instr_class = CLS_NOP;
        endcase
    end

    assign alu_op = alu_op_of(opcode);

endmodule
`default_nettype wire

// File: rtl/control_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : control_sequencer
// Brief    : Hardwired T0-T7 step sequencer producing datapath strobes.
// Revision : 1.0
// ============================================================================
module control_sequencer
    import cpu_ctrl_pkg::*;
(
    input  logic        clock,
    input  logic        clear,
    input  logic [31:0] IR,
    input  logic        CON,
    input  logic        Stop,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        BAout,
    output logic        PCin,
    output logic        PCout,
    output logic        IncPC,
    output logic        IRin,
    output logic        Yin,
    output logic        Zin,
    output logic        Zhighout,
    output logic        Zlowout,
    output logic        HIin,
    output logic        HIout,
    output logic        LOin,
    output logic        LOout,
    output logic        MARin,
    output logic        MDRin,
    output logic        MDRout,
    output logic        Read,
    output logic        Write,
    output logic        Cout,
    output logic        CONin,
    output logic [4:0]  ALU_op,
    output logic        Run
);

    state_t       r_state;
    instr_class_t w_cls;
    logic [4:0]   w_alu_op;
    logic [2:0]   w_step;
    logic         w_in_run;
    state_t       w_end_state;
    logic         w_unused_ir;

    // Register fields feed the select/encode logic directly, not the sequencer.
    assign w_unused_ir = ^IR[26:0];

    ctrl_decode u_decode (
        .opcode      (IR[31:27]),
        .instr_class (w_cls),
        .alu_op      (w_alu_op)
    );

    assign w_step      = r_state[2:0];
    assign w_in_run    = r_state[3];
    assign w_end_state = Stop ? ST_HALT : ST_T0;

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_state <= ST_RST;
        end else begin
            case (r_state)
                ST_RST:  r_state <= ST_T0;
                ST_T0:   r_state <= ST_T1;
                ST_T1:   r_state <= ST_T2;
                ST_T2:   r_state <= ST_T3;
                ST_T3: begin
                    case (w_cls)
                        CLS_HALT:                     r_state <= ST_HALT;
                        CLS_MFHI, CLS_MFLO, CLS_NOP:  r_state <= w_end_state;
                        default:                      r_state <= ST_T4;
                    endcase
                end
                ST_T4:   r_state <= ST_T5;
                ST_T5: begin
                    case (w_cls)
                        CLS_RALU, CLS_IALU, CLS_LDI:  r_state <= w_end_state;
                        default:                      r_state <= ST_T6;
                    endcase
                end
                ST_T6: begin
                    case (w_cls)
                        CLS_MULDIV, CLS_BR:           r_state <= w_end_state;
                        default:                      r_state <= ST_T7;
                    endcase
                end
                ST_T7:   r_state <= w_end_state;
                ST_HALT: r_state <= ST_HALT;
                default: r_state <= ST_RST;
            endcase
        end
    end

    // Strobes are decoded from the state so clear silences them without a clock.
    always_comb begin
        Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; Rin = 1'b0; Rout = 1'b0; BAout = 1'b0;
        PCin = 1'b0; PCout = 1'b0; IncPC = 1'b0; IRin = 1'b0; Yin = 1'b0; Zin = 1'b0;
        Zhighout = 1'b0; Zlowout = 1'b0; HIin = 1'b0; HIout = 1'b0; LOin = 1'b0;
        LOout = 1'b0; MARin = 1'b0; MDRin = 1'b0; MDRout = 1'b0; Read = 1'b0;
        Write = 1'b0; Cout = 1'b0; CONin = 1'b0;
        ALU_op = C_ALU_NONE;
        Run = w_in_run;
        if (w_in_run) begin
            case (w_step)
                3'd0: begin
                    PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
                end
                3'd1: begin
                    Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
                end
                3'd2: begin
                    MDRout = 1'b1; IRin = 1'b1;
                end
                3'd3: begin
                    case (w_cls)
                        CLS_RALU, CLS_IALU: begin
                            Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
                        end
                        CLS_MULDIV: begin
                            Gra = 1'b1; Rout = 1'b1; Yin = 1'b1;
                        end
                        CLS_LD, CLS_ST, CLS_LDI: begin
                            Grb = 1'b1; BAout = 1'b1; Yin = 1'b1;
                        end
                        CLS_BR: begin
                            Gra = 1'b1; Rout = 1'b1; CONin = 1'b1;
                        end
                        CLS_MFHI: begin
                            HIout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                        end
                        CLS_MFLO: begin
                            LOout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                        end
                        default: ;
                    endcase
                end
                3'd4: begin
                    case (w_cls)
                        CLS_RALU: begin
                            Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; ALU_op = w_alu_op;
                        end
                        CLS_MULDIV: begin
                            Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; ALU_op = w_alu_op;
                        end
                        CLS_IALU, CLS_LD, CLS_ST, CLS_LDI: begin
                            Cout = 1'b1; Zin = 1'b1; ALU_op = w_alu_op;
                        end
                        CLS_BR: begin
                            PCout = 1'b1; Yin = 1'b1;
                        end
                        default: ;
                    endcase
                end
                3'd5: begin
                    case (w_cls)
                        CLS_RALU, CLS_IALU, CLS_LDI: begin
                            Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                        end
                        CLS_MULDIV: begin
                            Zlowout = 1'b1; LOin = 1'b1;
                        end
                        CLS_LD, CLS_ST: begin
                            Zlowout = 1'b1; MARin = 1'b1;
                        end
                        CLS_BR: begin
                            Cout = 1'b1; Zin = 1'b1; ALU_op = C_ALU_ADD;
                        end
                        default: ;
                    endcase
                end
                3'd6: begin
                    case (w_cls)
                        CLS_MULDIV: begin
                            Zhighout = 1'b1; HIin = 1'b1;
                        end
                        CLS_LD: begin
                            Read = 1'b1; MDRin = 1'b1;
                        end
                        CLS_ST: begin
                            Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1;
                        end
                        CLS_BR: begin
                            Zlowout = CON; PCin = CON;
                        end
                        default: ;
                    endcase
                end
                default: begin
                    case (w_cls)
                        CLS_LD: begin
                            MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                        end
                        CLS_ST: Write = 1'b1;
                        default: ;
                    endcase
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 The block SHALL have port clock, input, 1: the single system clock; all state changes occur on its rising edge.
REQ-002 The block SHALL have port clear, input, 1: asynchronous, active-low reset.
REQ-003 The block SHALL have port IR, input, 32: the instruction register value from the datapath; opcode IR[31:27], Ra IR[26:23], Rb IR[22:19], Rc IR[18:15].
REQ-004 The block SHALL have port CON, input, 1: the branch-condition flip-flop output from the datapath.
REQ-005 The block SHALL have port Stop, input, 1: a halt request, sampled only at an instruction boundary.
REQ-006 The block SHALL have ports Gra, Grb, Grc, Rin, Rout, BAout, each output, 1: the register-field select and general-register strobes to the select/encode logic.
REQ-007 The block SHALL have ports PCin, PCout, IncPC, IRin, Yin, Zin, Zhighout, Zlowout, each output, 1: datapath register strobes.
REQ-008 The block SHALL have ports HIin, HIout, LOin, LOout, MARin, MDRin, MDRout, Read, Write, Cout, CONin, each output, 1: datapath and memory strobes.
REQ-009 The block SHALL have port ALU_op, output, 5: the ALU operation code.
REQ-010 The block SHALL have port Run, output, 1: high while instructions are executing.

Function
REQ-011 The states SHALL be RST, T0-T7 and HALT, with a 3-bit step index; all outputs SHALL be Moore, decoded from the state and the registered IR only.
REQ-012 Fetch SHALL be: T0 = PCout, MARin, IncPC, Zin; T1 = Zlowout, PCin, Read, MDRin; T2 = MDRout, IRin.
REQ-013 R-type ALU instructions (opcodes 00011-01011) SHALL execute as: T3 = Grb, Rout, Yin; T4 = Grc, Rout, ALU_op, Zin; T5 = Zlowout, Gra, Rin; then return to T0 (6 cycles total).
REQ-014 Immediate ALU instructions (01100-01110) SHALL execute as: T3 = Grb, Rout, Yin; T4 = Cout, ALU_op, Zin; T5 = Zlowout, Gra, Rin.
REQ-015 mul and div (01111, 10000) SHALL execute as: T3 = Gra, Rout, Yin; T4 = Grb, Rout, ALU_op, Zin; T5 = Zlowout, LOin; T6 = Zhighout, HIin.
REQ-016 ld and st (00000, 00010) SHALL share: T3 = Grb, BAout, Yin; T4 = Cout, ALU_op=ADD, Zin; T5 = Zlowout, MARin. ld SHALL continue T6 = Read, MDRin; T7 = MDRout, Gra, Rin. st SHALL continue T6 = Gra, Rout, MDRin; T7 = Write.
REQ-017 ldi (00001) SHALL execute as: T3 = Grb, BAout, Yin; T4 = Cout, ALU_op=ADD, Zin; T5 = Zlowout, Gra, Rin.
REQ-018 br (10010) SHALL execute as: T3 = Gra, Rout, CONin; T4 = PCout, Yin; T5 = Cout, ALU_op=ADD, Zin; T6 = Zlowout and PCin only if CON=1, otherwise no strobes; CON SHALL be sampled in T6.
REQ-019 mfhi and mflo (10111, 11000) SHALL execute as: T3 = HIout or LOout, plus Gra, Rin.
REQ-020 nop (11010) and any undefined opcode SHALL spend T3 with no strobes, then go to T0.
REQ-021 halt (11011) SHALL go from T3 to HALT.
REQ-022 HALT SHALL assert no strobes and hold Run=0; only reset SHALL exit HALT.
REQ-023 Stop=1 in the cycle an instruction would return to T0 SHALL cause a transition to HALT instead, so the current instruction always completes.
REQ-024 Stop SHALL be ignored at every other step.
REQ-025 ALU_op SHALL be 0 in every step that does not assert Zin.
REQ-026 At most one bus driver (any *out strobe, Rout, BAout, Cout) SHALL be asserted per cycle.

Reset
REQ-027 While clear=0, the block SHALL enter RST immediately (asynchronously, including mid-instruction) and drive every output to 0, with Run=0.
REQ-028 The first rising clock edge with clear=1 SHALL move RST to T0, with Run=1 from then on.

Structure
REQ-029 Opcode constants, ALU_op codes (ADD, SUB, AND, OR, SHR, SHL, ROR, ROL, MUL, DIV, NEG, NOT), the state enumeration and the opcode-to-ALU_op mapping SHALL live in a shared package, cpu_ctrl_pkg.
REQ-030 Opcode-class decode SHALL be one sub-module, ctrl_decode (IR to instruction class); the step FSM SHALL remain in control_sequencer.

Verification
REQ-031 Reset release, then IR=0x18918000 (add R1,R2,R3) -> T0..T5 strobes exactly as in REQ-012 and REQ-013, Gra+Rin in cycle 6, and T0 again in cycle 7.
REQ-032 IR=0x00800065 (ld R1,0x65(R0)) -> MARin in T5, Read+MDRin in T6, MDRout+Gra+Rin in T7, 8 cycles total.
REQ-033 br with CON=0, then repeat with CON=1 -> PCin absent in T6 / asserted in T6 together with Zlowout.
REQ-034 Stop raised during T4 of an add -> T5 completes, the next state is HALT, Run=0, and it holds for 10 cycles.
REQ-035 clear pulsed low during T6 of st -> all outputs 0 asynchronously and no Write is ever issued; fetch restarts at T0 on the first edge after release.
REQ-036 Undefined opcode 11111 -> one strobe-free T3, then T0; an every-cycle assertion checks REQ-026.
